// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction handshake, ALU operand/result wires, writeback and status.
interface alu_issue_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic             hold;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [2:0]       alu_op;
  logic [15:0]      alu_r;
  logic             alu_altb;
  logic             ex_valid;
  logic             wb_en;
  logic [2:0]       wb_addr;
  logic [15:0]      wb_data;
  logic             illegal;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output in_valid, in_instr, hold, alu_r, alu_altb,
    input  in_ready, alu_a, alu_b, alu_op, ex_valid, wb_en, wb_addr, wb_data,
           illegal, retire_count
  );

  modport slave (
    input  in_valid, in_instr, hold, alu_r, alu_altb,
    output in_ready, alu_a, alu_b, alu_op, ex_valid, wb_en, wb_addr, wb_data,
           illegal, retire_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around a combinational ALU: decode + regfile read with forwarding,
// one registered E stage, writeback on the following edge. Issue latency 1, throughput 1/cycle.
module alu_issue_stage #(
  parameter int NREGS = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [3:0]       opc;
  logic [2:0]       rd;
  logic [2:0]       rs;
  logic [2:0]       rt;
  logic [15:0]      imm6;
  logic [15:0]      imm9;
  logic [15:0]      rs_val;
  logic [15:0]      rt_val;
  logic [15:0]      dec_a;
  logic [15:0]      dec_b;
  logic [2:0]       dec_op;
  logic             dec_ill;

  logic [15:0]      rf [NREGS];
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic [2:0]       op_q;
  logic [2:0]       rd_q;
  logic [3:0]       opc_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ex_valid;
  logic             wb_en;
  logic [15:0]      wb_data;

  assign bus.in_ready = rst_n & ~bus.hold;
  assign accept       = bus.in_valid & bus.in_ready;

  assign opc  = bus.in_instr[15:12];
  assign rd   = bus.in_instr[11:9];
  assign rs   = bus.in_instr[8:6];
  assign rt   = bus.in_instr[5:3];
  assign imm6 = {{10{bus.in_instr[5]}}, bus.in_instr[5:0]};
  assign imm9 = {{7{bus.in_instr[8]}}, bus.in_instr[8:0]};

  // wb_en already excludes rd == 0, so R0 can never be a forwarding source
  assign rs_val = (wb_en && rd_q == rs) ? wb_data : ((rs == 3'd0) ? 16'h0000 : rf[rs]);
  assign rt_val = (wb_en && rd_q == rt) ? wb_data : ((rt == 3'd0) ? 16'h0000 : rf[rt]);

  always_comb begin
    dec_a   = 16'h0000;
    dec_b   = 16'h0000;
    dec_op  = 3'd2;
    dec_ill = 1'b0;
    case (opc)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        dec_a  = rs_val;
        dec_b  = rt_val;
        dec_op = opc[2:0];
      end
      4'd6: begin
        dec_a  = rs_val;
        dec_b  = imm6;
        dec_op = 3'd4;
      end
      4'd7: begin
        dec_a  = rs_val;
        dec_b  = imm6;
        dec_op = 3'd2;
      end
      4'd8: begin
        dec_b  = imm9;
        dec_op = 3'd1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (accept) state_nxt = BUSY;
  end

  assign ex_valid = (state == BUSY);
  assign wb_en    = ex_valid && (opc_q <= 4'd8) && (rd_q != 3'd0);
  assign wb_data  = (opc_q == 4'd5) ? {15'b0, bus.alu_altb} : bus.alu_r;

  // Operand registers only load on accept so the ALU inputs stay stable through bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      op_q  <= 3'd2;
      rd_q  <= 3'd0;
      opc_q <= 4'd0;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ill_q <= accept & dec_ill;
      if (accept) begin
        a_q   <= dec_a;
        b_q   <= dec_b;
        op_q  <= dec_op;
        rd_q  <= rd;
        opc_q <= opc;
      end
      if (ex_valid) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= 16'h0000;
    end else if (wb_en) begin
      rf[rd_q] <= wb_data;
    end
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_op       = op_q;
  assign bus.ex_valid     = ex_valid;
  assign bus.wb_en        = wb_en;
  assign bus.wb_addr      = rd_q;
  assign bus.wb_data      = wb_data;
  assign bus.illegal      = ill_q;
  assign bus.retire_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench: drives instructions, models the 16-bit ALU, checks operands, regfile and status.
module tb_alu_issue_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_issue_if #(.CNT_W(16)) bus ();

  alu_issue_stage #(.NREGS(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: shift op takes signed B (negative = right shift), altb is an unsigned compare
  always_comb begin
    bus.alu_r    = 16'h0000;
    bus.alu_altb = bus.alu_a < bus.alu_b;
    case (bus.alu_op)
      3'd0: bus.alu_r = bus.alu_a & bus.alu_b;
      3'd1: bus.alu_r = bus.alu_a | bus.alu_b;
      3'd2: bus.alu_r = bus.alu_a + bus.alu_b;
      3'd3: bus.alu_r = bus.alu_a - bus.alu_b;
      3'd4: bus.alu_r = bus.alu_b[15] ? (bus.alu_a >> (~bus.alu_b + 16'd1))
                                      : (bus.alu_a << bus.alu_b);
      default: bus.alu_r = bus.alu_a - bus.alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [15:0] instr);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0000;
    bus.hold     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_op", bus.alu_op, 2);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_count", bus.retire_count, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);

    // LI R1,5 ; LI R2,-3
    issue(16'h8205);
    chk("li1_alu_b", bus.alu_b, 16'h0005);
    chk("li1_alu_a", bus.alu_a, 16'h0000);
    chk("li1_alu_op", bus.alu_op, 1);
    chk("li1_ex_valid", bus.ex_valid, 1);
    issue(16'h85FD);
    chk("li2_alu_b", bus.alu_b, 16'hFFFD);
    chk("li_r1", dut.rf[1], 16'h0005);
    idle();
    chk("li_r2", dut.rf[2], 16'hFFFD);
    chk("li_count", bus.retire_count, 2);
    chk("bubble_ex_valid", bus.ex_valid, 0);
    chk("bubble_alu_b_hold", bus.alu_b, 16'hFFFD);

    // ADDI R3,R1,1 ; ADD R4,R3,R3 back to back
    issue(16'h7641);
    chk("addi_alu_a", bus.alu_a, 16'h0005);
    issue(16'h28D8);
    chk("fwd_alu_a", bus.alu_a, 16'h0006);
    chk("fwd_alu_b", bus.alu_b, 16'h0006);
    chk("fwd_ex_valid", bus.ex_valid, 1);
    idle();
    chk("addi_r3", dut.rf[3], 16'h0006);
    chk("add_r4", dut.rf[4], 16'h000C);
    chk("add_count", bus.retire_count, 4);

    // LI R1,0x10 then immediate shifts
    issue(16'h8210);
    issue(16'h6A7E);
    chk("shi_m2_alu_b", bus.alu_b, 16'hFFFE);
    chk("shi_m2_alu_a", bus.alu_a, 16'h0010);
    chk("shi_m2_alu_op", bus.alu_op, 4);
    issue(16'h6C43);
    issue(16'h6E40);
    idle();
    chk("shi_r5", dut.rf[5], 16'h0004);
    chk("shi_r6", dut.rf[6], 16'h0080);
    chk("shi_r7", dut.rf[7], 16'h0010);
    chk("shi_count", bus.retire_count, 8);

    // LI R1,5 ; SLT R3,R2,R1 ; SLT R3,R1,R2
    issue(16'h8205);
    issue(16'h5688);
    chk("slt_alu_b_fwd", bus.alu_b, 16'h0005);
    chk("slt_alu_op", bus.alu_op, 5);
    idle();
    chk("slt_r3_zero", dut.rf[3], 16'h0000);
    issue(16'h5650);
    idle();
    chk("slt_r3_one", dut.rf[3], 16'h0001);
    chk("slt_count", bus.retire_count, 11);

    // LI R0,7 ; ADD R1,R0,R0
    issue(16'h8007);
    chk("r0_wb_en", bus.wb_en, 0);
    issue(16'h2200);
    chk("r0_alu_a", bus.alu_a, 16'h0000);
    idle();
    chk("r0_stays_zero", dut.rf[0], 16'h0000);
    chk("r0_add_r1", dut.rf[1], 16'h0000);

    // illegal opcode
    issue(16'hF000);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_alu_op", bus.alu_op, 2);
    chk("ill_alu_a", bus.alu_a, 16'h0000);
    chk("ill_wb_en", bus.wb_en, 0);
    idle();
    chk("ill_flag_clr", bus.illegal, 0);
    chk("ill_count", bus.retire_count, 14);
    chk("ill_r2_kept", dut.rf[2], 16'hFFFD);

    // hold for 3 edges with an instruction in flight
    issue(16'h8A09);
    @(negedge clk);
    bus.hold     = 1'b1;
    bus.in_instr = 16'h8C01;
    #1;
    chk("hold_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("hold_ex_valid", bus.ex_valid, 0);
    chk("hold_r5_retired", dut.rf[5], 16'h0009);
    chk("hold_count", bus.retire_count, 15);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_r6_kept", dut.rf[6], 16'h0080);
    chk("hold_count_kept", bus.retire_count, 15);
    @(negedge clk);
    bus.hold = 1'b0;
    @(posedge clk);
    #1;
    chk("unhold_ex_valid", bus.ex_valid, 1);
    chk("unhold_alu_b", bus.alu_b, 16'h0001);
    idle();
    chk("unhold_r6", dut.rf[6], 16'h0001);
    chk("unhold_count", bus.retire_count, 16);

    // reset while BUSY drops the in-flight LI R7,0x55
    issue(16'h8E55);
    chk("busy_before_rst", bus.ex_valid, 1);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 0);
    chk("arst_wb_en", bus.wb_en, 0);
    chk("arst_alu_a", bus.alu_a, 0);
    chk("arst_alu_b", bus.alu_b, 0);
    chk("arst_alu_op", bus.alu_op, 2);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_count", bus.retire_count, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_r7_dropped", dut.rf[7], 16'h0000);
    chk("arst_r6_cleared", dut.rf[6], 16'h0000);
    chk("arst_in_ready_rel", bus.in_ready, 1);
    chk("arst_wb_en_rel", bus.wb_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
